// File: rtl/xosera_spi_bridge_pkg.sv
// ============================================================================
//  Module   : xosera_spi_bridge_pkg
//  Brief    : Shared constants, command-byte field positions and FSM state
//             encoding for the SPI-to-Xosera host-bus bridge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package xosera_spi_bridge_pkg;

  // Command byte field positions
  localparam int SPICMD_RNW     = 7;
  localparam int SPICMD_WORD    = 6;
  localparam int SPICMD_BYTESEL = 5;
  localparam int SPICMD_REG     = 0;
  localparam int SPICMD_REG_W   = 4;

  // Xosera host-bus signal polarities
  localparam logic cs_ENABLED  = 1'b0;
  localparam logic cs_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } spi_bridge_state_t;

  // Largest of three cycle counts; sizes the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xosera_spi_bridge_sync2.sv
// ============================================================================
//  Module   : xosera_sync2
//  Brief    : Two-flop synchronizer with asynchronous active-low reset and a
//             selectable reset value.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xosera_sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to resolve metastability
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/xosera_spi_bridge.sv
// ============================================================================
//  Module   : xosera_spi_bridge
//  Brief    : Converts an SPI command/data byte stream into timed Xosera
//             host-bus cycles and returns read data for SPI shift-out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xosera_spi_bridge
  import xosera_spi_bridge_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int CS_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       spi_cs_n_i,
  input  logic       receive_strobe_i,
  input  logic [7:0] receive_byte_i,
  input  logic       transmit_strobe_i,
  output logic [7:0] transmit_byte_o,
  output logic       bus_cs_n_o,
  output logic       bus_rd_nwr_o,
  output logic [3:0] bus_reg_num_o,
  output logic       bus_bytesel_o,
  output logic [7:0] bus_data_o,
  input  logic [7:0] bus_data_i,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, CS_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CS_LAST    = CNT_W'(CS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  spi_bridge_state_t state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic       bus_cs_n_q;
  logic       rd_nwr_q;
  logic [3:0] reg_num_q;
  logic       bytesel_q;
  logic [7:0] data_q;
  logic [7:0] tx_byte_q;
  logic       busy_q;
  logic       overrun_q;
  logic       word_q;
  logic       pend_valid_q;
  logic [7:0] pend_byte_q;
  logic       tx_pend_q;

  logic spi_cs_sync;
  logic cs_active;
  logic in_cycle;
  logic last_hold;

  xosera_sync2 #(
    .RESET_VALUE (1'b1)
  ) u_cs_sync (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .d_i       (spi_cs_n_i),
    .q_o       (spi_cs_sync)
  );

  assign cs_active = (spi_cs_sync == 1'b0);
  assign in_cycle  = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign last_hold = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST);

  // Bridge FSM: command decode, byte buffering and bus-cycle timing
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bus_cs_n_q   <= cs_DISABLED;
      rd_nwr_q     <= RnW_READ;
      reg_num_q    <= 4'h0;
      bytesel_q    <= 1'b0;
      data_q       <= 8'h00;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      word_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= 8'h00;
      tx_pend_q    <= 1'b0;
    end else begin
      // Absorb traffic that arrives while a bus cycle is running; the last
      // HOLD cycle handles its own arrivals because the pending slot frees up
      if (in_cycle && !last_hold) begin
        if (rd_nwr_q == RnW_WRITE && receive_strobe_i) begin
          if (pend_valid_q) begin
            overrun_q <= 1'b1;
          end else begin
            pend_valid_q <= 1'b1;
            pend_byte_q  <= receive_byte_i;
          end
        end
        if (rd_nwr_q == RnW_READ && transmit_strobe_i) begin
          tx_pend_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_active && receive_strobe_i) begin
            rd_nwr_q     <= receive_byte_i[SPICMD_RNW];
            word_q       <= receive_byte_i[SPICMD_WORD];
            reg_num_q    <= receive_byte_i[SPICMD_REG +: SPICMD_REG_W];
            bytesel_q    <= receive_byte_i[SPICMD_WORD] ? 1'b0 : receive_byte_i[SPICMD_BYTESEL];
            overrun_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            tx_pend_q    <= 1'b0;
            cnt_q        <= '0;
            if (receive_byte_i[SPICMD_RNW] == RnW_READ) begin
              state_q <= ST_SETUP;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!cs_active) begin
            state_q <= ST_IDLE;
          end else if (rd_nwr_q == RnW_WRITE && receive_strobe_i) begin
            data_q  <= receive_byte_i;
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (rd_nwr_q == RnW_READ && transmit_strobe_i) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q      <= '0;
            bus_cs_n_q <= cs_ENABLED;
            state_q    <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STROBE: begin
          if (cnt_q == CS_LAST) begin
            cnt_q      <= '0;
            bus_cs_n_q <= cs_DISABLED;
            state_q    <= ST_HOLD;
            if (rd_nwr_q == RnW_READ) begin
              tx_byte_q <= bus_data_i;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            if (word_q) begin
              bytesel_q <= ~bytesel_q;
            end
            if (!cs_active) begin
              // Frame ended during the cycle: drop anything still queued
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
              pend_valid_q <= 1'b0;
              tx_pend_q    <= 1'b0;
            end else if (rd_nwr_q == RnW_WRITE) begin
              if (pend_valid_q) begin
                data_q       <= pend_byte_q;
                state_q      <= ST_SETUP;
                pend_valid_q <= receive_strobe_i;
                if (receive_strobe_i) begin
                  pend_byte_q <= receive_byte_i;
                end
              end else if (receive_strobe_i) begin
                data_q  <= receive_byte_i;
                state_q <= ST_SETUP;
              end else begin
                state_q <= ST_WAIT;
                busy_q  <= 1'b0;
              end
            end else begin
              tx_pend_q <= 1'b0;
              if (tx_pend_q || transmit_strobe_i) begin
                state_q <= ST_SETUP;
              end else begin
                state_q <= ST_WAIT;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign transmit_byte_o = tx_byte_q;
  assign bus_cs_n_o      = bus_cs_n_q;
  assign bus_rd_nwr_o    = rd_nwr_q;
  assign bus_reg_num_o   = reg_num_q;
  assign bus_bytesel_o   = bytesel_q;
  assign bus_data_o      = data_q;
  assign busy_o          = busy_q;
  assign overrun_o       = overrun_q;

endmodule

`default_nettype wire

// File: doc/xosera_spi_bridge.md
# xosera_spi_bridge

Translates the byte stream delivered by `spi_target` into Xosera host-bus cycles on `xosera_main`'s `bus_*` inputs, and returns read data to `spi_target` for shift-out. Sits between `spi_target` and `xosera_main` in the SPI_INTERFACE build of the iCEBreaker top, in the `pclk` domain. Each SPI frame is one command byte followed by a stream of data bytes. Each data byte becomes one timed chip-select strobe.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles that address, data and `rd_nwr` are stable before `bus_cs_n_o` falls (≥1).
- `CS_CYCLES`, default 4: cycles `bus_cs_n_o` is held low (≥2).
- `HOLD_CYCLES`, default 1: cycles `bus_cs_n_o` is high with signals held after a strobe (≥1).

Ports:
- `clk`  in  1  pixel clock (`pclk`). Single clock domain.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `spi_cs_n_i`  in  1  raw SPI select. Asynchronous; synchronized internally with 2 flops.
- `receive_strobe_i`  in  1  one-cycle pulse: `receive_byte_i` is valid.
- `receive_byte_i`  in  8  byte received from the SPI controller.
- `transmit_strobe_i`  in  1  one-cycle pulse: `spi_target` has latched `transmit_byte_o`.
- `transmit_byte_o`  out  8  next byte to shift out.
- `bus_cs_n_o`  out  1  to `bus_cs_n_i` (`cs_ENABLED` = 0).
- `bus_rd_nwr_o`  out  1  to `bus_rd_nwr_i` (`RnW_READ` = 1).
- `bus_reg_num_o`  out  4  register index.
- `bus_bytesel_o`  out  1  byte select: even = 0, odd = 1.
- `bus_data_o`  out  8  write data to `xosera_main` `bus_data_i`.
- `bus_data_i`  in  8  read data from `xosera_main` `bus_data_o`.
- `busy_o`  out  1  high while a bus cycle is in progress (SETUP, STROBE or HOLD).
- `overrun_o`  out  1  sticky. Set when a write byte is dropped.

## Operation
- Command byte fields: [7] rd_nwr; [6] word mode; [5] bytesel, used only in byte mode; [4] reserved, ignored; [3:0] reg_num.
- Byte select per data byte:
  - Byte mode: every data byte uses cmd[5].
  - Word mode: starts at 0 and toggles after every completed cycle.
- States: IDLE, WAIT, SETUP, STROBE, HOLD.
- IDLE:
  - The next `receive_strobe_i` while the synchronized CS is low is the command.
  - On a command: latch the fields and clear `overrun_o`.
  - Write command → WAIT. Read command → SETUP.
- Write:
  - WAIT + strobe → latch the byte into `bus_data_o`, go to SETUP.
  - One pending-byte register absorbs a byte that arrives during SETUP/STROBE/HOLD.
  - At the end of HOLD: if a byte is pending, go to SETUP with it; otherwise go to WAIT.
  - A byte arriving while the pending register is full is dropped and sets `overrun_o`.
- Read:
  - Receive strobes are ignored, because they carry dummy bytes.
  - At the end of HOLD, `transmit_byte_o` holds the sampled data. Go to WAIT and wait for `transmit_strobe_i`, then go to SETUP.
  - A `transmit_strobe_i` that arrives during a cycle is remembered (1 bit) and launches the next cycle right after HOLD.
- SPI CS deasserted (synchronized high):
  - In WAIT: go to IDLE immediately.
  - In SETUP/STROBE/HOLD: finish the cycle (a strobe is never truncated), then go to IDLE.
  - The pending byte and the remembered transmit strobe are discarded.
- Reset values: `bus_cs_n_o` = 1, `bus_rd_nwr_o` = 1, `bus_reg_num_o` = 0, `bus_bytesel_o` = 0, `bus_data_o` = 0, `transmit_byte_o` = 0x00, `busy_o` = 0, `overrun_o` = 0. State = IDLE; the CS synchronizer resets to 1.
- Asserting reset mid-cycle forces all of the above immediately; this is the one case where a strobe is truncated.

## Timing
- Write latency: strobe in cycle N → SETUP from N+1 for `SETUP_CYCLES` → `bus_cs_n_o` low from N+1+`SETUP_CYCLES` for exactly `CS_CYCLES` → HOLD for `HOLD_CYCLES`.
- `bus_reg_num_o`, `bus_bytesel_o`, `bus_rd_nwr_o` and `bus_data_o` are constant from the first SETUP cycle through the last HOLD cycle.
- Read sampling: `bus_data_i` is registered on the clock edge that ends the last STROBE cycle. It is visible on `transmit_byte_o` during HOLD.
- Back-to-back cycles: `bus_cs_n_o` is high for at least `HOLD_CYCLES` + `SETUP_CYCLES` cycles.
- Throughput constraint, placed on the system rather than the block: one SPI byte time must be ≥ `SETUP_CYCLES` + `CS_CYCLES` + `HOLD_CYCLES` + 2 pclk cycles.
- CS synchronizer latency is 2 cycles.

## Structure
- Add to `xosera_defs.svh`: command bit-position constants (`SPICMD_RNW`, `SPICMD_WORD`, `SPICMD_BYTESEL`, `SPICMD_REG`) and the state enum. Reuse the existing `cs_ENABLED` and `RnW_READ` constants.
- One sub-module: `xosera_sync2`, a 2-flop synchronizer with asynchronous active-low reset and a reset value parameter. The rest of the bridge is a single FSM with a phase counter sized to the largest of the three cycle parameters.

## Test plan
- Reset: assert `reset_n_i` low mid-STROBE → `bus_cs_n_o` = 1 in the same cycle, all outputs at their reset values, state IDLE.
- Byte write: command 0x23, data 0xA5 → one strobe: 1 setup cycle, then `bus_cs_n_o` low for 4 cycles with `bus_reg_num_o` = 3, `bus_bytesel_o` = 1, `bus_rd_nwr_o` = 0, `bus_data_o` = 0xA5.
- Word write stream: command 0x49, data 0x12 0x34 0x56 0x78 → four strobes on register 9, bytesel 0/1/0/1, data in order.
- Word read: command 0xC5, bus model returns 0xBE on even and 0xEF on odd → `transmit_byte_o` = 0xBE; after `transmit_strobe_i`, a second strobe with bytesel 1 and `transmit_byte_o` = 0xEF.
- Overrun: three write bytes 0x01, 0x02, 0x03 strobed 1 cycle apart → 0x01 and 0x02 go out, 0x03 is dropped, `overrun_o` = 1 until the next command byte.
- CS deasserted during STROBE → the strobe completes its full 4 cycles, state returns to IDLE, and the next received byte is decoded as a command.
